store_result_monitor: RTL and testbench

Synthesizable responder on the CPU data-store port (`memwrite`, `dataaddr`, `writedata`). It judges a self-checking program from the stores the program issues:
- a milestone store to one address;
- a pass store to another;
- a cycle watchdog as a backstop.

It exposes a sticky pass/fail verdict that benches and FPGA builds can read. It sits beside the data memory, snooping the same store bus, and never stalls the CPU.

---
 rtl/store_result_monitor_if.sv | 30 +++
 rtl/store_result_monitor.sv | 131 +++++++++++++
 tb/tb_store_result_monitor.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/store_result_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : store_result_monitor_if
// Description : CPU data-store snoop bus plus the verdict outputs of
//               store_result_monitor. The master is the CPU/bench side, the
//               slave is the monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_result_monitor_if;
    logic        memwrite;
    logic [31:0] dataaddr;
    logic [31:0] writedata;
    logic        done;
    logic        pass;
    logic [2:0]  fail_code;
    logic [7:0]  milestone_cnt;
    logic [7:0]  stray_cnt;
    logic [15:0] cycles;

    modport master (
        output memwrite, dataaddr, writedata,
        input  done, pass, fail_code, milestone_cnt, stray_cnt, cycles
    );

    modport slave (
        input  memwrite, dataaddr, writedata,
        output done, pass, fail_code, milestone_cnt, stray_cnt, cycles
    );
endinterface
`default_nettype wire

// File: rtl/store_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : store_result_monitor
// Description : Snoops the CPU store bus and produces a sticky pass/fail
//               verdict from milestone/pass stores, with a cycle watchdog.
//               Optional macro STORE_MON_STRICT_ADDR_EN turns any store to a
//               non-target address into a failure (code 4).
// Revision    : 1.0 - initial release
// ============================================================================
module store_result_monitor #(
    parameter int MILESTONE_ADDR = 80,
    parameter int PASS_ADDR      = 84,
    parameter int EXPECT_DATA    = 7,
    parameter int MIN_MILESTONES = 1,
    parameter int TIMEOUT        = 90
) (
    input  wire logic             clk,
    input  wire logic             reset,
    store_result_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    localparam logic [31:0] c_MS_ADDR      = 32'(MILESTONE_ADDR);
    localparam logic [31:0] c_PASS_ADDR    = 32'(PASS_ADDR);
    localparam logic [31:0] c_EXPECT       = 32'(EXPECT_DATA);
    localparam logic [31:0] c_MIN_MS       = 32'(MIN_MILESTONES);
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT - 1);

    localparam logic [2:0]  c_FC_NONE      = 3'd0;
    localparam logic [2:0]  c_FC_BAD_MS    = 3'd1;
    localparam logic [2:0]  c_FC_BAD_PASS  = 3'd2;
    localparam logic [2:0]  c_FC_TIMEOUT   = 3'd3;
    localparam logic [2:0]  c_FC_STRAY     = 3'd4;
    localparam logic [2:0]  c_FC_EARLY     = 3'd5;

    state_t      r_state;
    logic [2:0]  r_fail_code;
    logic [7:0]  r_ms_cnt;
    logic [7:0]  r_stray_cnt;
    logic [15:0] r_cycles;

    state_t      w_next_state;
    logic [2:0]  w_next_code;
    logic [7:0]  w_next_ms;
    logic [7:0]  w_next_stray;
    logic        w_terminate;
    logic        w_is_ms;
    logic        w_is_pass;
    logic        w_data_ok;

    assign w_is_ms   = (bus.dataaddr == c_MS_ADDR);
    assign w_is_pass = (bus.dataaddr == c_PASS_ADDR);
    assign w_data_ok = (bus.writedata == c_EXPECT);

    // State, verdict code and counters; reset drops any same-edge store.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_fail_code <= c_FC_NONE;
            r_ms_cnt    <= 8'd0;
            r_stray_cnt <= 8'd0;
            r_cycles    <= 16'd0;
        end else begin
            r_state     <= w_next_state;
            r_fail_code <= w_next_code;
            r_ms_cnt    <= w_next_ms;
            r_stray_cnt <= w_next_stray;
            if (r_cycles != 16'hFFFF) begin
                r_cycles <= r_cycles + 16'd1;
            end
        end
    end

    // Judge the sampled store while running; a terminating store beats the watchdog.
    always_comb begin
        w_next_state = r_state;
        w_next_code  = r_fail_code;
        w_next_ms    = r_ms_cnt;
        w_next_stray = r_stray_cnt;
        w_terminate  = 1'b0;
        if (r_state == ST_RUN) begin
            if (bus.memwrite) begin
                if (w_is_ms) begin
                    if (w_data_ok) begin
                        w_next_ms = (r_ms_cnt == 8'hFF) ? r_ms_cnt : r_ms_cnt + 8'd1;
                    end else begin
                        w_terminate  = 1'b1;
                        w_next_state = ST_FAIL;
                        w_next_code  = c_FC_BAD_MS;
                    end
                end else if (w_is_pass) begin
                    w_terminate = 1'b1;
                    if (!w_data_ok) begin
                        w_next_state = ST_FAIL;
                        w_next_code  = c_FC_BAD_PASS;
                    end else if ({24'd0, r_ms_cnt} < c_MIN_MS) begin
                        w_next_state = ST_FAIL;
                        w_next_code  = c_FC_EARLY;
                    end else begin
                        w_next_state = ST_PASS;
                    end
                end else begin
                    w_next_stray = (r_stray_cnt == 8'hFF) ? r_stray_cnt : r_stray_cnt + 8'd1;
`ifdef STORE_MON_STRICT_ADDR_EN
                    w_terminate  = 1'b1;
                    w_next_state = ST_FAIL;
                    w_next_code  = c_FC_STRAY;
`endif
                end
            end
            if (!w_terminate && (r_cycles == c_TIMEOUT_LAST)) begin
                w_next_state = ST_FAIL;
                w_next_code  = c_FC_TIMEOUT;
            end
        end
    end

    assign bus.done          = (r_state != ST_RUN);
    assign bus.pass          = (r_state == ST_PASS);
    assign bus.fail_code     = r_fail_code;
    assign bus.milestone_cnt = r_ms_cnt;
    assign bus.stray_cnt     = r_stray_cnt;
    assign bus.cycles        = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_store_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_result_monitor
// Description : Directed self-checking bench for store_result_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_result_monitor;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    store_result_monitor_if u_if ();

    store_result_monitor u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        u_if.memwrite  = 1'b1;
        u_if.dataaddr  = a;
        u_if.writedata = d;
        step(1);
        u_if.memwrite  = 1'b0;
        u_if.dataaddr  = 32'd0;
        u_if.writedata = 32'd0;
    endtask

    task automatic run_nominal(input string tag);
        step(20);
        store(32'd80, 32'd7);
        step(19);
        n_assert++; if (u_if.cycles !== 16'd40) begin n_fail++; $display("FAIL %s_cycles_before_pass got=%0d exp=40", tag, u_if.cycles); end
        store(32'd84, 32'd7);
        n_assert++; if (u_if.done !== 1'b1) begin n_fail++; $display("FAIL %s_done got=%0d exp=1", tag, u_if.done); end
        n_assert++; if (u_if.pass !== 1'b1) begin n_fail++; $display("FAIL %s_pass got=%0d exp=1", tag, u_if.pass); end
        n_assert++; if (u_if.fail_code !== 3'd0) begin n_fail++; $display("FAIL %s_code got=%0d exp=0", tag, u_if.fail_code); end
        n_assert++; if (u_if.milestone_cnt !== 8'd1) begin n_fail++; $display("FAIL %s_ms got=%0d exp=1", tag, u_if.milestone_cnt); end
    endtask

    task automatic test_reset();
        do_reset();
        n_assert++; if (u_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0d exp=0", u_if.done); end
        n_assert++; if (u_if.pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got=%0d exp=0", u_if.pass); end
        n_assert++; if (u_if.fail_code !== 3'd0) begin n_fail++; $display("FAIL reset_code got=%0d exp=0", u_if.fail_code); end
        n_assert++; if (u_if.milestone_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ms got=%0d exp=0", u_if.milestone_cnt); end
        n_assert++; if (u_if.stray_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_stray got=%0d exp=0", u_if.stray_cnt); end
        n_assert++; if (u_if.cycles !== 16'd0) begin n_fail++; $display("FAIL reset_cycles got=%0d exp=0", u_if.cycles); end
        step(1);
        n_assert++; if (u_if.cycles !== 16'd1) begin n_fail++; $display("FAIL reset_cycles_inc got=%0d exp=1", u_if.cycles); end
    endtask

    task automatic test_nominal();
        do_reset();
        run_nominal("nominal");
        step(3);
        n_assert++; if (u_if.cycles !== 16'd44) begin n_fail++; $display("FAIL nominal_cycles_after got=%0d exp=44", u_if.cycles); end
        n_assert++; if (u_if.pass !== 1'b1) begin n_fail++; $display("FAIL nominal_sticky got=%0d exp=1", u_if.pass); end
    endtask

    task automatic test_no_strobe();
        do_reset();
        u_if.memwrite  = 1'b0;
        u_if.dataaddr  = 32'd80;
        u_if.writedata = 32'd6;
        step(2);
        u_if.dataaddr  = 32'd0;
        u_if.writedata = 32'd0;
        n_assert++; if (u_if.done !== 1'b0) begin n_fail++; $display("FAIL nostrobe_done got=%0d exp=0", u_if.done); end
        n_assert++; if (u_if.stray_cnt !== 8'd0) begin n_fail++; $display("FAIL nostrobe_stray got=%0d exp=0", u_if.stray_cnt); end
    endtask

    task automatic test_bad_data();
        do_reset();
        store(32'd80, 32'd6);
        n_assert++; if (u_if.done !== 1'b1) begin n_fail++; $display("FAIL badms_done got=%0d exp=1", u_if.done); end
        n_assert++; if (u_if.fail_code !== 3'd1) begin n_fail++; $display("FAIL badms_code got=%0d exp=1", u_if.fail_code); end
        store(32'd84, 32'd7);
        n_assert++; if (u_if.pass !== 1'b0) begin n_fail++; $display("FAIL badms_sticky_pass got=%0d exp=0", u_if.pass); end
        n_assert++; if (u_if.milestone_cnt !== 8'd0) begin n_fail++; $display("FAIL badms_ms got=%0d exp=0", u_if.milestone_cnt); end
        n_assert++; if (u_if.fail_code !== 3'd1) begin n_fail++; $display("FAIL badms_sticky_code got=%0d exp=1", u_if.fail_code); end
        do_reset();
        store(32'd80, 32'd7);
        store(32'd84, 32'd8);
        n_assert++; if (u_if.fail_code !== 3'd2) begin n_fail++; $display("FAIL badpass_code got=%0d exp=2", u_if.fail_code); end
        n_assert++; if (u_if.pass !== 1'b0) begin n_fail++; $display("FAIL badpass_pass got=%0d exp=0", u_if.pass); end
    endtask

    task automatic test_early_pass();
        do_reset();
        store(32'd84, 32'd7);
        n_assert++; if (u_if.done !== 1'b1) begin n_fail++; $display("FAIL early_done got=%0d exp=1", u_if.done); end
        n_assert++; if (u_if.fail_code !== 3'd5) begin n_fail++; $display("FAIL early_code got=%0d exp=5", u_if.fail_code); end
    endtask

    task automatic test_timeout();
        do_reset();
        step(89);
        n_assert++; if (u_if.cycles !== 16'd89) begin n_fail++; $display("FAIL tmo_cycles89 got=%0d exp=89", u_if.cycles); end
        n_assert++; if (u_if.done !== 1'b0) begin n_fail++; $display("FAIL tmo_early_done got=%0d exp=0", u_if.done); end
        step(1);
        n_assert++; if (u_if.done !== 1'b1) begin n_fail++; $display("FAIL tmo_done got=%0d exp=1", u_if.done); end
        n_assert++; if (u_if.cycles !== 16'd90) begin n_fail++; $display("FAIL tmo_cycles got=%0d exp=90", u_if.cycles); end
        n_assert++; if (u_if.fail_code !== 3'd3) begin n_fail++; $display("FAIL tmo_code got=%0d exp=3", u_if.fail_code); end
        // collision: pass store on the watchdog edge wins
        do_reset();
        step(2);
        store(32'd80, 32'd7);
        step(86);
        n_assert++; if (u_if.cycles !== 16'd89) begin n_fail++; $display("FAIL coll_cycles got=%0d exp=89", u_if.cycles); end
        store(32'd84, 32'd7);
        n_assert++; if (u_if.pass !== 1'b1) begin n_fail++; $display("FAIL coll_pass got=%0d exp=1", u_if.pass); end
        n_assert++; if (u_if.fail_code !== 3'd0) begin n_fail++; $display("FAIL coll_code got=%0d exp=0", u_if.fail_code); end
    endtask

    task automatic test_stray();
        do_reset();
        store(32'd100, 32'd1);
        store(32'd80, 32'd7);
        store(32'd84, 32'd7);
        n_assert++; if (u_if.stray_cnt !== 8'd1) begin n_fail++; $display("FAIL stray_cnt got=%0d exp=1", u_if.stray_cnt); end
        n_assert++; if (u_if.done !== 1'b1) begin n_fail++; $display("FAIL stray_done got=%0d exp=1", u_if.done); end
`ifdef STORE_MON_STRICT_ADDR_EN
        n_assert++; if (u_if.fail_code !== 3'd4) begin n_fail++; $display("FAIL stray_code got=%0d exp=4", u_if.fail_code); end
        n_assert++; if (u_if.milestone_cnt !== 8'd0) begin n_fail++; $display("FAIL stray_ms got=%0d exp=0", u_if.milestone_cnt); end
`else
        n_assert++; if (u_if.pass !== 1'b1) begin n_fail++; $display("FAIL stray_pass got=%0d exp=1", u_if.pass); end
        n_assert++; if (u_if.fail_code !== 3'd0) begin n_fail++; $display("FAIL stray_code got=%0d exp=0", u_if.fail_code); end
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        store(32'd80, 32'd7);
        store(32'd80, 32'd7);
        store(32'd84, 32'd7);
        n_assert++; if (u_if.milestone_cnt !== 8'd2) begin n_fail++; $display("FAIL b2b_ms got=%0d exp=2", u_if.milestone_cnt); end
        n_assert++; if (u_if.pass !== 1'b1) begin n_fail++; $display("FAIL b2b_pass got=%0d exp=1", u_if.pass); end
        n_assert++; if (u_if.cycles !== 16'd3) begin n_fail++; $display("FAIL b2b_cycles got=%0d exp=3", u_if.cycles); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        store(32'd80, 32'd7);
        n_assert++; if (u_if.milestone_cnt !== 8'd1) begin n_fail++; $display("FAIL midrun_pre_ms got=%0d exp=1", u_if.milestone_cnt); end
        reset = 1'b1;
        store(32'd80, 32'd7);
        reset = 1'b0;
        n_assert++; if (u_if.milestone_cnt !== 8'd0) begin n_fail++; $display("FAIL midrun_ms got=%0d exp=0", u_if.milestone_cnt); end
        n_assert++; if (u_if.cycles !== 16'd0) begin n_fail++; $display("FAIL midrun_cycles got=%0d exp=0", u_if.cycles); end
        n_assert++; if (u_if.done !== 1'b0) begin n_fail++; $display("FAIL midrun_done got=%0d exp=0", u_if.done); end
        run_nominal("midrun_nominal");
        reset = 1'b1;
        store(32'd80, 32'd7);
        reset = 1'b0;
        n_assert++; if (u_if.done !== 1'b0) begin n_fail++; $display("FAIL postverdict_done got=%0d exp=0", u_if.done); end
        n_assert++; if (u_if.pass !== 1'b0) begin n_fail++; $display("FAIL postverdict_pass got=%0d exp=0", u_if.pass); end
        n_assert++; if (u_if.milestone_cnt !== 8'd0) begin n_fail++; $display("FAIL postverdict_ms got=%0d exp=0", u_if.milestone_cnt); end
        n_assert++; if (u_if.fail_code !== 3'd0) begin n_fail++; $display("FAIL postverdict_code got=%0d exp=0", u_if.fail_code); end
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        u_if.memwrite  = 1'b0;
        u_if.dataaddr  = 32'd0;
        u_if.writedata = 32'd0;
        step(2);
        test_reset();
        test_nominal();
        test_no_strobe();
        test_bad_data();
        test_early_pass();
        test_timeout();
        test_stray();
        test_back_to_back();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
